spm_seq_ctrl: RTL and testbench
===============================

Name: spm_seq_ctrl

Overview:
- Sequencer placed directly around the serial/parallel multiplier (spm).
- Accepts a parallel operand pair over a valid/ready handshake and holds multiplier `a` steady on the array.
- Streams multiplicand `x` LSB-first, then zero-pads it.
- Deserialises the bit-serial product back into a 2*BITS-wide word and presents it over a valid/ready output handshake.

Parameters:
- BITS, 32, operand width; must equal the multiplier's `bits` parameter.
- CW, $clog2(2*BITS+1), cycle-counter width; derived, not overridden.

Ports:
- clk  in  1  clock; shared with the multiplier.
- rst  in  1  asynchronous active-low reset; the same net also resets the multiplier.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept operands.
- in_a  in  BITS  multiplier operand, unsigned.
- in_x  in  BITS  multiplicand operand, unsigned.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts the product.
- out_p  out  2*BITS  product in_a*in_x, unsigned.
- busy  out  1  high in RUN or DONE.
- spm_x  out  1  serial multiplicand bit to the multiplier.
- spm_a  out  BITS  parallel multiplier operand to the multiplier.
- spm_y  in  1  serial product bit from the multiplier.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All registers clear: a_reg, x_sr, p_sr, cnt.
  - Outputs: in_ready=1, out_valid=0, out_p=0, spm_x=0, spm_a=0, busy=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On a clock edge with in_valid=1: a_reg<=in_a, x_sr<=in_x, p_sr<=0, cnt<=0, go to RUN.
- RUN:
  - in_ready=0.
  - spm_x = x_sr[0], driven from a register with no combinational path from inputs.
  - Each edge: x_sr shifts right with zero fill, so the multiplier sees x bits 0..BITS-1 followed by BITS zeros. cnt increments.
  - Each edge with cnt>=1: p_sr <= {spm_y, p_sr[2*BITS-1:1]}. The value on spm_y during cycle k is product bit k-1.
  - On the edge with cnt==2*BITS: capture the final bit and go to DONE.
  - RUN lasts exactly 2*BITS+1 cycles.
- DONE:
  - out_valid=1 and out_p=p_sr, held stable until the handshake.
  - Go to IDLE on the edge where out_ready=1.
  - No new operand is accepted in the same cycle; in_ready returns high the cycle after.
- spm_a = a_reg at all times after the first accept; a_reg changes only on accept.
- spm_x = 0 in IDLE and DONE.
- Latency: out_valid rises 2*BITS+1 cycles after the accepting edge.
- Minimum issue interval is 2*BITS+3 cycles when out_ready is held high.
- Inter-operation flushing: the zero-padded tail drains every multiplier carry and sum register to 0 by the end of RUN, so back-to-back operations need no reset.
- Overflow: none. The product is always < 2^(2*BITS); the full width is returned and nothing is truncated.
- Input changes while in RUN or DONE: ignored; in_ready is low.
- Output stall: out_ready held low keeps DONE and out_p stable indefinitely.
- Reset mid-RUN or mid-DONE: the operation is discarded and out_valid never asserts for it. Because the multiplier shares rst, the next operation starts from a clean array.
- Operand zero: handled identically; the sequencer takes no early-exit shortcut.

Test Plan:
- BITS=32: in_a=3, in_x=5 -> out_valid exactly 65 cycles after accept, out_p=15.
- BITS=32: in_a=in_x=0xFFFFFFFF -> out_p=0xFFFFFFFE00000001.
- Back-to-back with out_ready=1, no reset between: (0x12345678,0x9ABCDEF0) then (7,0) then (1,0xFFFFFFFF) -> out_p sequence:
  - 0x0B00EA4E242D2080
  - 0
  - 0xFFFFFFFF
- Consumer stall: hold out_ready=0 for 20 cycles after out_valid -> out_p stable, in_ready=0 throughout, in_valid pulses ignored. Release -> in_ready=1 on the next cycle.
- Reset mid-RUN: assert rst at cycle 30 of a (9,9) operation, release, then issue (6,7) -> no output for the first operation, second out_p=42.
- BITS=8 with a matching multiplier: in_a=in_x=255 -> out_p=0xFE01 after 17 cycles; random 1000-pair scoreboard against a*x matches.

Source files
------------

// File: rtl/spm_seq_ctrl.sv
// Operand/result sequencer wrapped around a bit-serial/parallel multiplier.
// Holds `a` on the array, streams `x` LSB-first with zero padding, and rebuilds the product.
module spm_seq_ctrl #(
    parameter  int BITS = 32,
    localparam int CW   = $clog2(2*BITS+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BITS-1:0]   in_a,
    input  logic [BITS-1:0]   in_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*BITS-1:0] out_p,
    output logic              busy,
    output logic              spm_x,
    output logic [BITS-1:0]   spm_a,
    input  logic              spm_y
);

    localparam logic [1:0]    S_IDLE = 2'd0;
    localparam logic [1:0]    S_RUN  = 2'd1;
    localparam logic [1:0]    S_DONE = 2'd2;
    localparam logic [CW-1:0] C_LAST = CW'(2*BITS);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_busy;
    logic [BITS-1:0]   r_a;
    logic [BITS-1:0]   r_x;
    logic [2*BITS-1:0] r_p;
    logic [CW-1:0]     r_cnt;

    // Next-state decode for the IDLE/RUN/DONE sequence.
    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (in_valid) w_state_nxt = S_RUN;
                else          w_state_nxt = S_IDLE;
            end
            S_RUN: begin
                if (r_cnt == C_LAST) w_state_nxt = S_DONE;
                else                 w_state_nxt = S_RUN;
            end
            S_DONE: begin
                if (out_ready) w_state_nxt = S_IDLE;
                else           w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register; handshake flags are registered from the next state so they never glitch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
            r_busy      <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DONE);
        end
    end

    // Operand capture, multiplicand shift-out and product shift-in.
    // Product bit k arrives one cycle after x bit k, so sampling starts at cnt==1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a   <= {BITS{1'b0}};
            r_x   <= {BITS{1'b0}};
            r_p   <= {(2*BITS){1'b0}};
            r_cnt <= {CW{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a   <= in_a;
                        r_x   <= in_x;
                        r_p   <= {(2*BITS){1'b0}};
                        r_cnt <= {CW{1'b0}};
                    end
                end
                S_RUN: begin
                    r_x   <= {1'b0, r_x[BITS-1:1]};
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt != {CW{1'b0}}) begin
                        r_p <= {spm_y, r_p[2*BITS-1:1]};
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // x_sr has fully drained to zero by DONE, so spm_x is zero outside RUN without gating.
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_p     = r_p;
    assign spm_x     = r_x[0];
    assign spm_a     = r_a;

endmodule

// File: tb/tb_spm_seq_ctrl.sv
// Directed bench for spm_seq_ctrl at BITS=32 and BITS=8, each driving a behavioural serial multiplier.
module tb_spm_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // 32-bit sequencer
    logic        in_valid_s, in_ready_s, out_valid_s, out_ready_s, busy_s, spm_x_s, spm_y_s;
    logic [31:0] in_a_s, in_x_s, spm_a_s;
    logic [63:0] out_p_s;

    spm_seq_ctrl #(.BITS(32)) u_dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_s), .in_ready(in_ready_s), .in_a(in_a_s), .in_x(in_x_s),
        .out_valid(out_valid_s), .out_ready(out_ready_s), .out_p(out_p_s),
        .busy(busy_s), .spm_x(spm_x_s), .spm_a(spm_a_s), .spm_y(spm_y_s)
    );

    // 8-bit sequencer
    logic        in_valid8_s, in_ready8_s, out_valid8_s, out_ready8_s, busy8_s, spm_x8_s, spm_y8_s;
    logic [7:0]  in_a8_s, in_x8_s, spm_a8_s;
    logic [15:0] out_p8_s;

    spm_seq_ctrl #(.BITS(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8_s), .in_ready(in_ready8_s), .in_a(in_a8_s), .in_x(in_x8_s),
        .out_valid(out_valid8_s), .out_ready(out_ready8_s), .out_p(out_p8_s),
        .busy(busy8_s), .spm_x(spm_x8_s), .spm_a(spm_a8_s), .spm_y(spm_y8_s)
    );

    // Serial/parallel multiplier models: add a when x bit is set, emit LSB next cycle, keep the rest.
    logic [31:0] m32_s;
    logic [32:0] m32_t;
    logic [7:0]  m8_s;
    logic [8:0]  m8_t;
    assign m32_t = {1'b0, m32_s} + (spm_x_s  ? {1'b0, spm_a_s}  : 33'd0);
    assign m8_t  = {1'b0, m8_s}  + (spm_x8_s ? {1'b0, spm_a8_s} : 9'd0);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m32_s <= 32'd0; spm_y_s  <= 1'b0;
            m8_s  <= 8'd0;  spm_y8_s <= 1'b0;
        end else begin
            m32_s <= m32_t[32:1]; spm_y_s  <= m32_t[0];
            m8_s  <= m8_t[8:1];   spm_y8_s <= m8_t[0];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one 32-bit operation; returns #1 after the edge on which out_valid rose.
    task automatic op32(input logic [31:0] a, input logic [31:0] x, input logic [63:0] exp, input string tag);
        int n;
        in_valid_s = 1'b1; in_a_s = a; in_x_s = x;
        n = 0;
        while (!in_ready_s && n < 300) begin @(posedge clk); #1; n++; end
        chk({tag, "_ready_bound"}, 64'(n < 300), 64'd1);
        @(posedge clk); #1;
        in_valid_s = 1'b0;
        chk({tag, "_busy"}, 64'(busy_s), 64'd1);
        chk({tag, "_spm_a"}, 64'(spm_a_s), 64'(a));
        n = 0;
        while (!out_valid_s && n < 300) begin @(posedge clk); #1; n++; end
        chk({tag, "_latency"}, 64'(n), 64'd65);
        chk({tag, "_p"}, out_p_s, exp);
        chk({tag, "_spm_x_done"}, 64'(spm_x_s), 64'd0);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] x, input logic [15:0] exp, input string tag);
        int n;
        in_valid8_s = 1'b1; in_a8_s = a; in_x8_s = x;
        n = 0;
        while (!in_ready8_s && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid8_s = 1'b0;
        n = 0;
        while (!out_valid8_s && n < 100) begin @(posedge clk); #1; n++; end
        chk({tag, "_latency"}, 64'(n), 64'd17);
        chk({tag, "_p"}, 64'(out_p8_s), 64'(exp));
    endtask

    initial begin
        int          seen;
        logic [7:0]  ra, rx;
        logic [15:0] rexp;

        in_valid_s = 1'b0; in_a_s = 32'd0; in_x_s = 32'd0; out_ready_s = 1'b1;
        in_valid8_s = 1'b0; in_a8_s = 8'd0; in_x8_s = 8'd0; out_ready8_s = 1'b1;

        // Reset state
        #2 rst = 1'b0;
        #1;
        chk("rst_in_ready",  64'(in_ready_s),  64'd1);
        chk("rst_out_valid", 64'(out_valid_s), 64'd0);
        chk("rst_out_p",     out_p_s,          64'd0);
        chk("rst_spm_x",     64'(spm_x_s),     64'd0);
        chk("rst_spm_a",     64'(spm_a_s),     64'd0);
        chk("rst_busy",      64'(busy_s),      64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // Basic products and boundaries
        op32(32'd3, 32'd5, 64'd15, "small");
        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "max");

        // Back-to-back without reset
        op32(32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080, "b2b0");
        op32(32'd7, 32'd0, 64'd0, "b2b1");
        op32(32'd1, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF, "b2b2");

        // Consumer stall with ignored operand pulses
        @(posedge clk); #1;
        out_ready_s = 1'b0;
        op32(32'h0001_0001, 32'h0001_0001, 64'h0000_0001_0002_0001, "stall");
        for (int i = 0; i < 20; i++) begin
            in_valid_s = i[0]; in_a_s = 32'hDEAD_0000 + 32'(i); in_x_s = 32'd99;
            @(posedge clk); #1;
            chk("stall_p",         out_p_s,           64'h0000_0001_0002_0001);
            chk("stall_in_ready",  64'(in_ready_s),   64'd0);
            chk("stall_out_valid", 64'(out_valid_s),  64'd1);
        end
        in_valid_s = 1'b0;
        out_ready_s = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready",  64'(in_ready_s),  64'd1);
        chk("release_out_valid", 64'(out_valid_s), 64'd0);
        @(posedge clk); #1;
        chk("release_idle_busy", 64'(busy_s), 64'd0);
        chk("release_spm_a",     64'(spm_a_s), 64'h0001_0001);

        // Reset in the middle of RUN
        in_valid_s = 1'b1; in_a_s = 32'd9; in_x_s = 32'd9;
        @(posedge clk); #1;
        in_valid_s = 1'b0;
        repeat (29) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid_s), 64'd0);
        chk("midrst_in_ready",  64'(in_ready_s),  64'd1);
        chk("midrst_busy",      64'(busy_s),      64'd0);
        chk("midrst_spm_a",     64'(spm_a_s),     64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            if (out_valid_s) seen++;
        end
        chk("midrst_no_output", 64'(seen), 64'd0);
        op32(32'd6, 32'd7, 64'd42, "after_rst");
        @(posedge clk); #1;

        // Narrow instance: extreme value then a scoreboard over random pairs
        op8(8'd255, 8'd255, 16'hFE01, "b8_max");
        op8(8'd0, 8'd200, 16'd0, "b8_zero");
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rx = 8'($urandom_range(0, 255));
            rexp = 16'(ra) * 16'(rx);
            op8(ra, rx, rexp, "b8_rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
